sdram_cmd_sequencer: RTL and testbench

SDRAM_CMD_SEQUENCER -- requirements
Module: sdram_cmd_sequencer

---
 rtl/sdram_cmd_sequencer_if.sv | 22 ++
 rtl/sdram_cmd_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sdram_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_sequencer_if.sv
// Request/acknowledge bundle between an access requester and the SDRAM command sequencer.
interface sdram_cmd_sequencer_if;
   logic        req;
   logic        req_wr;
   logic [1:0]  req_bank;
   logic [11:0] req_row;
   logic [7:0]  req_col;
   logic        ref_req;
   logic        ack;
   logic        ref_ack;
   logic        done;

   modport master (
      output req, req_wr, req_bank, req_row, req_col, ref_req,
      input  ack, ref_ack, done
   );

   modport slave (
      input  req, req_wr, req_bank, req_row, req_col, ref_req,
      output ack, ref_ack, done
   );
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: init chain, access (ACT/RW/PRE) and refresh sequencing
// against an external delay generator; all outputs registered from the next state.
module sdram_cmd_sequencer (
   input  logic                        clk,
   input  logic                        reset,
   sdram_cmd_sequencer_if.slave        host,
   input  logic [9:0]                  program_data,
   input  logic [9:0]                  countout,
   input  logic [2:0]                  tlat,
   output logic                        load_twait,
   output logic                        load_tpre,
   output logic                        load_tcas,
   output logic                        load_tburst,
   output logic                        busy,
   output logic                        init_done,
   output logic                        cs_n,
   output logic                        ras_n,
   output logic                        cas_n,
   output logic                        we_n,
   output logic [1:0]                  ba,
   output logic [11:0]                 a
);
   typedef enum logic [4:0] {
      S_INIT, S_INIT_W, S_IPRE, S_IPRE_W, S_IREF1, S_IREF1_W, S_IREF2, S_IREF2_W,
      S_MRS, S_MRS_W, S_IDLE, S_ACT, S_ACT_W, S_RW, S_RW_W, S_RD_LAT,
      S_PRE, S_PRE_W, S_REF, S_REF_W
   } state_t;

   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_LMR   = 4'b0000;

   state_t      state_q, state_d;
   logic        hold_q;
   logic [2:0]  lat_q, lat_d;
   logic        wr_q, wr_d;
   logic [1:0]  bank_q, bank_d;
   logic [11:0] row_q, row_d;
   logic [7:0]  col_q, col_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [3:0]  ld_q, ld_d;
   logic [1:0]  ba_q, ba_d;
   logic [11:0] a_q, a_d;
   logic        ack_q, ref_ack_q, done_q, busy_q, init_done_q;
   logic        cnt_zero;

   assign cnt_zero = (countout == '0);

   // hold_q keeps INIT for one extra edge after reset so its load_twait is a full registered cycle
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      wr_d    = wr_q;
      bank_d  = bank_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         S_INIT:    state_d = hold_q ? S_INIT : S_INIT_W;
         S_INIT_W:  if (cnt_zero) state_d = S_IPRE;
         S_IPRE:    state_d = S_IPRE_W;
         S_IPRE_W:  if (cnt_zero) state_d = S_IREF1;
         S_IREF1:   state_d = S_IREF1_W;
         S_IREF1_W: if (cnt_zero) state_d = S_IREF2;
         S_IREF2:   state_d = S_IREF2_W;
         S_IREF2_W: if (cnt_zero) state_d = S_MRS;
         S_MRS:     state_d = S_MRS_W;
         S_MRS_W:   if (cnt_zero) state_d = S_IDLE;
         S_IDLE: begin
            if (host.ref_req) begin
               state_d = S_REF;
            end else if (host.req) begin
               state_d = S_ACT;
               wr_d    = host.req_wr;
               bank_d  = host.req_bank;
               row_d   = host.req_row;
               col_d   = host.req_col;
            end
         end
         S_ACT:     state_d = S_ACT_W;
         S_ACT_W:   if (cnt_zero) state_d = S_RW;
         S_RW:      state_d = S_RW_W;
         S_RW_W: begin
            if (cnt_zero) begin
               if (wr_q) begin
                  state_d = S_PRE;
               end else begin
                  state_d = S_RD_LAT;
                  lat_d   = (tlat == 3'd0) ? 3'd0 : tlat - 3'd1;
               end
            end
         end
         S_RD_LAT: begin
            if (lat_q == '0) state_d = S_PRE;
            else             lat_d   = lat_q - 3'd1;
         end
         S_PRE:     state_d = S_PRE_W;
         S_PRE_W:   if (cnt_zero) state_d = S_IDLE;
         S_REF:     state_d = S_REF_W;
         S_REF_W:   if (cnt_zero) state_d = S_IDLE;
         default:   state_d = S_INIT;
      endcase
   end

   // Strobe order in ld_d: {twait, tpre, tcas, tburst}
   always_comb begin
      cmd_d = CMD_NOP;
      ld_d  = '0;
      ba_d  = '0;
      a_d   = '0;
      case (state_d)
         S_INIT:  ld_d = 4'b1000;
         S_IPRE: begin
            cmd_d  = CMD_PRE;
            a_d[10] = 1'b1;
            ld_d   = 4'b0100;
         end
         S_IREF1, S_IREF2, S_REF: begin
            cmd_d = CMD_REF;
            ld_d  = 4'b1000;
         end
         S_MRS: begin
            cmd_d = CMD_LMR;
            a_d   = {2'b00, program_data};
            ld_d  = 4'b1000;
         end
         S_ACT: begin
            cmd_d = CMD_ACT;
            ba_d  = bank_d;
            a_d   = row_d;
            ld_d  = 4'b0010;
         end
         S_RW: begin
            cmd_d = wr_d ? CMD_WRITE : CMD_READ;
            ba_d  = bank_d;
            a_d   = {4'b0000, col_d};
            ld_d  = 4'b0001;
         end
         S_PRE: begin
            cmd_d = CMD_PRE;
            ba_d  = bank_d;
            ld_d  = 4'b0100;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_INIT;
         hold_q      <= 1'b1;
         lat_q       <= '0;
         wr_q        <= 1'b0;
         bank_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         cmd_q       <= CMD_NOP;
         ld_q        <= '0;
         ba_q        <= '0;
         a_q         <= '0;
         ack_q       <= 1'b0;
         ref_ack_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b1;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= 1'b0;
         lat_q       <= lat_d;
         wr_q        <= wr_d;
         bank_q      <= bank_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cmd_q       <= cmd_d;
         ld_q        <= ld_d;
         ba_q        <= ba_d;
         a_q         <= a_d;
         ack_q       <= (state_d == S_ACT);
         ref_ack_q   <= (state_d == S_REF);
         done_q      <= (state_q == S_PRE_W) && (state_d == S_IDLE);
         busy_q      <= (state_d != S_IDLE);
         init_done_q <= init_done_q | (state_d == S_IDLE);
      end
   end

   assign {cs_n, ras_n, cas_n, we_n}                     = cmd_q;
   assign {load_twait, load_tpre, load_tcas, load_tburst} = ld_q;
   assign ba           = ba_q;
   assign a            = a_q;
   assign host.ack     = ack_q;
   assign host.ref_ack = ref_ack_q;
   assign host.done    = done_q;
   assign busy         = busy_q;
   assign init_done    = init_done_q;
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer: per-cycle output log checked against a table of expected records.
module tb_sdram_cmd_sequencer;
   localparam int LOGN = 256;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_LMR = 4'b0000;

   localparam int A_RST = 0, A_INIT1 = 1, A_WR = 2, A_RD = 3, A_REF = 4, A_MID = 5, A_INIT2 = 6, A_TC0 = 7;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [11:0] a;
      logic [3:0]  ld;     // {twait, tpre, tcas, tburst}
      logic        ack;
      logic        rack;
      logic        done;
      logic        busy;
      logic        initd;
   } obs_t;

   typedef struct {
      int    anc;
      int    off;
      obs_t  exp;
      string name;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  program_data = 10'h233;
   logic [9:0]  countout;
   logic [2:0]  tlat = 3'd4;
   logic        load_twait, load_tpre, load_tcas, load_tburst;
   logic        busy, init_done;
   logic        cs_n, ras_n, cas_n, we_n;
   logic [1:0]  ba;
   logic [11:0] a;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          anc [8];
   obs_t        log_a [LOGN];
   vec_t        vt [$];

   int unsigned tw = 3, tp = 3, tc = 3, tb = 4;
   logic [9:0]  dg_q = '0;

   sdram_cmd_sequencer_if host ();

   sdram_cmd_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .host         (host.slave),
      .program_data (program_data),
      .countout     (countout),
      .tlat         (tlat),
      .load_twait   (load_twait),
      .load_tpre    (load_tpre),
      .load_tcas    (load_tcas),
      .load_tburst  (load_tburst),
      .busy         (busy),
      .init_done    (init_done),
      .cs_n         (cs_n),
      .ras_n        (ras_n),
      .cas_n        (cas_n),
      .we_n         (we_n),
      .ba           (ba),
      .a            (a)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Delay generator: loads on a strobe, otherwise free-running down-counter (wraps past 0)
   always @(posedge clk) begin
      if (load_twait)       dg_q <= 10'(tw);
      else if (load_tpre)   dg_q <= 10'(tp);
      else if (load_tcas)   dg_q <= 10'(tc);
      else if (load_tburst) dg_q <= 10'(tb);
      else                  dg_q <= dg_q - 10'd1;
   end
   assign countout = dg_q;

   always @(negedge clk) begin
      if (cyc < LOGN)
         log_a[cyc] = {cs_n, ras_n, cas_n, we_n, ba, a,
                       load_twait, load_tpre, load_tcas, load_tburst,
                       host.ack, host.ref_ack, host.done, busy, init_done};
   end

   function automatic obs_t mk(input logic [3:0] c, input logic [1:0] b, input logic [11:0] ad,
                               input logic [3:0] ld, input logic ak, input logic rk,
                               input logic dn, input logic bs, input logic id);
      return {c, b, ad, ld, ak, rk, dn, bs, id};
   endfunction

   function automatic void add(input int an, input int off, input obs_t e, input string n);
      vec_t v;
      v.anc  = an;
      v.off  = off;
      v.exp  = e;
      v.name = n;
      vt.push_back(v);
   endfunction

   task automatic at_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic check_int(input string n, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", n, got, exp);
      end
   endtask

   task automatic count_pulses(input int lo, input int hi, output int nd, output int na, output int nr);
      nd = 0; na = 0; nr = 0;
      for (int i = lo; i <= hi; i++) begin
         if (log_a[i].done === 1'b1) nd++;
         if (log_a[i].ack  === 1'b1) na++;
         if (log_a[i].rack === 1'b1) nr++;
      end
   endtask

   initial begin
      int an, idx, nd, na, nr;
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
      an = 0; idx = 0; nd = 0; na = 0; nr = 0;
   end

   initial begin
      int an, idx, nd, na, nr;

      // Expected-output table: {anchor, cycle offset, expected outputs, name}
      for (int k = 0; k < 3; k++) add(A_RST, k, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 0), "reset_hold");
      for (int k = 0; k < 2; k++) begin
         an = (k == 0) ? A_INIT1 : A_INIT2;
         add(an, 0,  mk(C_NOP, 2'd0, 12'h000, 4'b1000, 0, 0, 0, 1, 0), "init_nop");
         add(an, 1,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 0), "init_w");
         add(an, 5,  mk(C_PRE, 2'd0, 12'h400, 4'b0100, 0, 0, 0, 1, 0), "init_pre");
         add(an, 10, mk(C_REF, 2'd0, 12'h000, 4'b1000, 0, 0, 0, 1, 0), "init_ref1");
         add(an, 15, mk(C_REF, 2'd0, 12'h000, 4'b1000, 0, 0, 0, 1, 0), "init_ref2");
         add(an, 20, mk(C_LMR, 2'd0, 12'h233, 4'b1000, 0, 0, 0, 1, 0), "init_mrs");
         add(an, 24, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 0), "init_mrs_w");
         add(an, 25, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 0, 1), "init_idle");
      end
      add(A_WR, 0,  mk(C_ACT, 2'd1, 12'h123, 4'b0010, 1, 0, 0, 1, 1), "wr_act");
      add(A_WR, 1,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "wr_act_w");
      add(A_WR, 5,  mk(C_WR,  2'd1, 12'h045, 4'b0001, 0, 0, 0, 1, 1), "wr_write");
      add(A_WR, 11, mk(C_PRE, 2'd1, 12'h000, 4'b0100, 0, 0, 0, 1, 1), "wr_pre");
      add(A_WR, 15, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "wr_pre_w");
      add(A_WR, 16, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 1, 0, 1), "wr_done");
      add(A_WR, 17, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 0, 1), "wr_done_1cyc");
      add(A_RD, 0,  mk(C_ACT, 2'd1, 12'h123, 4'b0010, 1, 0, 0, 1, 1), "rd_act");
      add(A_RD, 5,  mk(C_RD,  2'd1, 12'h045, 4'b0001, 0, 0, 0, 1, 1), "rd_read");
      add(A_RD, 14, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "rd_lat_last");
      add(A_RD, 15, mk(C_PRE, 2'd1, 12'h000, 4'b0100, 0, 0, 0, 1, 1), "rd_pre");
      add(A_RD, 20, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 1, 0, 1), "rd_done");
      add(A_REF, 0,  mk(C_REF, 2'd0, 12'h000, 4'b1000, 0, 1, 0, 1, 1), "ref_cmd");
      add(A_REF, 5,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 0, 1), "ref_idle_nodone");
      add(A_REF, 6,  mk(C_ACT, 2'd2, 12'h0AB, 4'b0010, 1, 0, 0, 1, 1), "ref_then_act");
      add(A_REF, 7,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "ref_no_dup_ack");
      add(A_REF, 11, mk(C_WR,  2'd2, 12'h012, 4'b0001, 0, 0, 0, 1, 1), "ref_latched_write");
      add(A_REF, 22, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 1, 0, 1), "ref_acc_done");
      add(A_REF, 23, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 0, 1), "ref_stay_idle");
      add(A_MID, 0,  mk(C_ACT, 2'd3, 12'h3C5, 4'b0010, 1, 0, 0, 1, 1), "mid_act");
      add(A_MID, 5,  mk(C_WR,  2'd3, 12'h09A, 4'b0001, 0, 0, 0, 1, 1), "mid_write");
      add(A_MID, 8,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 0), "mid_reset");
      add(A_TC0, 0,  mk(C_ACT, 2'd0, 12'h001, 4'b0010, 1, 0, 0, 1, 1), "tc0_act");
      add(A_TC0, 1,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "tc0_act_w");
      add(A_TC0, 2,  mk(C_RD,  2'd0, 12'h0FF, 4'b0001, 0, 0, 0, 1, 1), "tc0_read");
      add(A_TC0, 8,  mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 0, 1, 1), "tc0_rdlat");
      add(A_TC0, 9,  mk(C_PRE, 2'd0, 12'h000, 4'b0100, 0, 0, 0, 1, 1), "tc0_pre");
      add(A_TC0, 14, mk(C_NOP, 2'd0, 12'h000, 4'b0000, 0, 0, 1, 0, 1), "tc0_done");

      host.req = 1'b0; host.req_wr = 1'b0; host.req_bank = '0;
      host.req_row = '0; host.req_col = '0; host.ref_req = 1'b0;

      // Reset release and init
      anc[A_RST] = 1;
      at_cycle(3);
      reset = 1'b0;
      anc[A_INIT1] = 4;

      // Write access; request fields scrambled after ack to confirm latching
      anc[A_WR] = anc[A_INIT1] + 27;
      at_cycle(anc[A_WR] - 1);
      host.req = 1'b1; host.req_wr = 1'b1; host.req_bank = 2'd1;
      host.req_row = 12'h123; host.req_col = 8'h45;
      at_cycle(anc[A_WR]);
      host.req = 1'b0; host.req_bank = 2'd2; host.req_row = 12'hFFF; host.req_col = 8'hFF;

      // Read access, tlat=4, tlat changed while in RD_LAT
      anc[A_RD] = anc[A_WR] + 18;
      at_cycle(anc[A_RD] - 1);
      host.req = 1'b1; host.req_wr = 1'b0; host.req_bank = 2'd1;
      host.req_row = 12'h123; host.req_col = 8'h45; tlat = 3'd4;
      at_cycle(anc[A_RD]);
      host.req = 1'b0;
      at_cycle(anc[A_RD] + 11);
      tlat = 3'd7;

      // Refresh and access requested together
      anc[A_REF] = anc[A_RD] + 22;
      at_cycle(anc[A_REF] - 1);
      host.ref_req = 1'b1; host.req = 1'b1; host.req_wr = 1'b1;
      host.req_bank = 2'd2; host.req_row = 12'h0AB; host.req_col = 8'h12;
      at_cycle(anc[A_REF]);
      host.ref_req = 1'b0;
      at_cycle(anc[A_REF] + 6);
      host.req = 1'b0; host.req_bank = 2'd1; host.req_row = 12'h555; host.req_col = 8'h66;

      // Reset during RW_W of a write
      anc[A_MID] = anc[A_REF] + 24;
      at_cycle(anc[A_MID] - 1);
      host.req = 1'b1; host.req_wr = 1'b1; host.req_bank = 2'd3;
      host.req_row = 12'h3C5; host.req_col = 8'h9A;
      at_cycle(anc[A_MID]);
      host.req = 1'b0;
      at_cycle(anc[A_MID] + 7);
      reset = 1'b1;
      at_cycle(anc[A_MID] + 8);
      reset = 1'b0;
      anc[A_INIT2] = anc[A_MID] + 9;

      // tcas=0, tlat=0 read
      anc[A_TC0] = anc[A_INIT2] + 27;
      at_cycle(anc[A_TC0] - 1);
      tc = 0; tlat = 3'd0;
      host.req = 1'b1; host.req_wr = 1'b0; host.req_bank = 2'd0;
      host.req_row = 12'h001; host.req_col = 8'hFF;
      at_cycle(anc[A_TC0]);
      host.req = 1'b0;
      at_cycle(anc[A_TC0] + 18);

      for (int i = 0; i < vt.size(); i++) begin
         idx = anc[vt[i].anc] + vt[i].off;
         checks++;
         if (log_a[idx] !== vt[i].exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", vt[i].name, idx, log_a[idx], vt[i].exp);
         end
      end

      count_pulses(anc[A_REF], anc[A_REF] + 21, nd, na, nr);
      check_int("ref_window_done", nd, 0);
      check_int("ref_window_ack", na, 1);
      count_pulses(anc[A_MID], anc[A_INIT2] + 26, nd, na, nr);
      check_int("mid_window_done", nd, 0);
      check_int("mid_window_ack", na, 1);
      count_pulses(1, anc[A_TC0] + 18, nd, na, nr);
      check_int("total_done", nd, 4);
      check_int("total_ack", na, 5);
      check_int("total_ref_ack", nr, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
